// File: rtl/dyt_mem_ctrl.sv
// Memory access controller in front of a word SRAM that writes every edge:
// IF/LS arbitration, store RMW merging, load alignment and one-cycle responses.
module dyt_mem_ctrl #(
    parameter int MEM_BYTES = 4096,
    parameter int WORD_W    = 32
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              if_req_valid,
    input  logic [WORD_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [WORD_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    input  logic              ls_req_we,
    input  logic [1:0]        ls_req_size,
    input  logic              ls_req_unsigned,
    input  logic [WORD_W-1:0] ls_req_addr,
    input  logic [WORD_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [WORD_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    output logic [WORD_W-1:0] sram_r_addr,
    input  logic [WORD_W-1:0] sram_r_data,
    output logic [WORD_W-1:0] sram_w_addr,
    output logic [WORD_W-1:0] sram_w_data
);
    localparam int AW = $clog2(MEM_BYTES / 4);
    localparam logic [WORD_W-1:0] MEM_LIMIT = WORD_W'(MEM_BYTES);

    // Handshake: a request transfers in the cycle its valid and ready are both
    // high; ready is the grant. Responses pulse for exactly the next cycle.
    logic              last_grant;
    logic              grant_if, grant_ls;
    logic              if_err, ls_err;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] merged;

    logic              if_rsp_valid_q, if_rsp_err_q;
    logic [WORD_W-1:0] if_rsp_word_q;
    logic              ls_rsp_valid_q, ls_rsp_err_q, ls_load_q, ls_uns_q;
    logic [WORD_W-1:0] ls_word_q;
    logic [1:0]        ls_lane_q, ls_size_q;
    logic [7:0]        ls_byte;
    logic [15:0]       ls_half;
    logic [WORD_W-1:0] ls_ext;

    // The port that did not win the last grant wins a contention.
    always_comb begin
        grant_ls = rst && ls_req_valid && (!if_req_valid || !last_grant);
        grant_if = rst && if_req_valid && !grant_ls;
    end

    always_comb begin
        case (ls_req_size)
            2'b00:   ls_err = 1'b0;
            2'b01:   ls_err = ls_req_addr[0];
            2'b10:   ls_err = |ls_req_addr[1:0];
            default: ls_err = 1'b1;
        endcase
        if (ls_req_addr >= MEM_LIMIT) ls_err = 1'b1;
        if_err = (|if_req_addr[1:0]) || (if_req_addr >= MEM_LIMIT);
    end

    always_comb begin
        word_idx = '0;
        if (grant_ls)      word_idx = ls_req_addr[AW+1:2];
        else if (grant_if) word_idx = if_req_addr[AW+1:2];
    end

    assign sram_r_addr = {{(WORD_W-AW){1'b0}}, word_idx};
    assign sram_w_addr = sram_r_addr;

    always_comb begin
        merged = sram_r_data;
        case (ls_req_size)
            2'b00:   merged[{ls_req_addr[1:0], 3'b000} +: 8] = ls_req_wdata[7:0];
            2'b01:   merged[{ls_req_addr[1], 4'b0000} +: 16] = ls_req_wdata[15:0];
            default: merged = ls_req_wdata;
        endcase
    end

    // Erroring stores fall back to a refresh, so out-of-range addresses never alias.
    assign sram_w_data = (grant_ls && ls_req_we && !ls_err) ? merged : sram_r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant     <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            if_rsp_word_q  <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_err_q   <= 1'b0;
            ls_load_q      <= 1'b0;
            ls_word_q      <= '0;
            ls_lane_q      <= 2'b00;
            ls_size_q      <= 2'b00;
            ls_uns_q       <= 1'b0;
        end else begin
            if_rsp_valid_q <= grant_if;
            if_rsp_err_q   <= grant_if && if_err;
            if_rsp_word_q  <= (grant_if && !if_err) ? sram_r_data : '0;
            ls_rsp_valid_q <= grant_ls;
            ls_rsp_err_q   <= grant_ls && ls_err;
            ls_load_q      <= grant_ls && !ls_req_we && !ls_err;
            if (grant_ls) begin
                ls_word_q <= sram_r_data;
                ls_lane_q <= ls_req_addr[1:0];
                ls_size_q <= ls_req_size;
                ls_uns_q  <= ls_req_unsigned;
            end
            if (grant_if || grant_ls) last_grant <= grant_ls;
        end
    end

    always_comb begin
        ls_byte = ls_word_q[{ls_lane_q, 3'b000} +: 8];
        ls_half = ls_word_q[{ls_lane_q[1], 4'b0000} +: 16];
        case (ls_size_q)
            2'b00:   ls_ext = ls_uns_q ? {{(WORD_W-8){1'b0}}, ls_byte}
                                       : {{(WORD_W-8){ls_byte[7]}}, ls_byte};
            2'b01:   ls_ext = ls_uns_q ? {{(WORD_W-16){1'b0}}, ls_half}
                                       : {{(WORD_W-16){ls_half[15]}}, ls_half};
            default: ls_ext = ls_word_q;
        endcase
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;
    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_err   = if_rsp_err_q;
    assign if_rsp_data  = if_rsp_word_q;
    assign ls_rsp_valid = ls_rsp_valid_q;
    assign ls_rsp_err   = ls_rsp_err_q;
    assign ls_rsp_data  = ls_load_q ? ls_ext : '0;
endmodule

// File: tb/tb_dyt_mem_ctrl.sv
// Directed bench for dyt_mem_ctrl with a behavioural SRAM that writes every edge.
module tb_dyt_mem_ctrl;
    logic        rst, clk;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_we, ls_req_unsigned, ls_req_ready;
    logic        ls_rsp_valid, ls_rsp_err;
    logic [1:0]  ls_req_size;
    logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [31:0] sram_r_addr, sram_r_data, sram_w_addr, sram_w_data;
    logic [31:0] mem [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;

    dyt_mem_ctrl dut (
        .rst(rst), .clk(clk),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_size(ls_req_size),
        .ls_req_unsigned(ls_req_unsigned), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .ls_rsp_err(ls_rsp_err), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_r_data = mem[sram_r_addr[9:0]];
    always @(posedge clk) mem[sram_w_addr[9:0]] <= sram_w_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
    endtask

    task automatic ls_op(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err);
        if_req_valid    = 1'b0;
        ls_req_valid    = 1'b1;
        ls_req_we       = we;
        ls_req_size     = size;
        ls_req_unsigned = uns;
        ls_req_addr     = addr;
        ls_req_wdata    = wdata;
        #1 chk({tag, ".ready"}, 32'(ls_req_ready), 1);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(ls_rsp_valid), 1);
        chk({tag, ".data"}, ls_rsp_data, exp_data);
        chk({tag, ".err"}, 32'(ls_rsp_err), 32'(exp_err));
        chk({tag, ".if_valid"}, 32'(if_rsp_valid), 0);
        ls_req_valid = 1'b0;
    endtask

    task automatic if_op(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        #1 chk({tag, ".ready"}, 32'(if_req_ready), 1);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(if_rsp_valid), 1);
        chk({tag, ".data"}, if_rsp_data, exp_data);
        chk({tag, ".err"}, 32'(if_rsp_err), 32'(exp_err));
        if_req_valid = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".if_valid"}, 32'(if_rsp_valid), 0);
        chk({tag, ".ls_valid"}, 32'(ls_rsp_valid), 0);
        chk({tag, ".ls_data"}, ls_rsp_data, 0);
        chk({tag, ".if_data"}, if_rsp_data, 0);
        chk({tag, ".ls_err"}, 32'(ls_rsp_err), 0);
        chk({tag, ".if_err"}, 32'(if_rsp_err), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_size = 2'b10;
        ls_req_unsigned = 1'b0; ls_req_addr = 32'h104; ls_req_wdata = 32'h0;

        // Reset state with both requesters pending.
        #23;
        chk_quiet("rst");
        chk("rst.if_ready", 32'(if_req_ready), 0);
        chk("rst.ls_ready", 32'(ls_req_ready), 0);
        chk("rst.sram_idx", sram_r_addr, 0);
        idle_in();
        @(negedge clk);
        rst = 1'b1;

        // First grant on the first edge after release.
        ls_op("st_w0",   1'b1, 2'b10, 1'b0, 32'h000, 32'hCAFEF00D, 32'h0, 1'b0);
        ls_op("st_w4",   1'b1, 2'b10, 1'b0, 32'h004, 32'h11223344, 32'h0, 1'b0);
        ls_op("st_w100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        ls_op("ld_w100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        ls_op("st_b101", 1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFF7F, 32'h0, 1'b0);
        chk("mem_100_after_sb", mem[32'h40], 32'hDEAD7FEF);
        ls_op("lb_101",  1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000007F, 1'b0);
        ls_op("lbu_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000007F, 1'b0);
        ls_op("lh_102",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0);
        ls_op("lhu_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 1'b0);
        ls_op("lbu_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000DE, 1'b0);
        ls_op("lb_103",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0);
        ls_op("lb_100",  1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hFFFFFFEF, 1'b0);
        ls_op("sh_202",  1'b1, 2'b01, 1'b0, 32'h202, 32'h1234A5A5, 32'h0, 1'b0);
        ls_op("ld_w200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hA5A50000, 1'b0);
        if_op("fetch_100", 32'h100, 32'hDEAD7FEF, 1'b0);

        // Contention: IF won last, so LS first, then alternate.
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_size = 2'b10;
        ls_req_unsigned = 1'b0; ls_req_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb.ls_ready", 32'(ls_req_ready), (i % 2 == 0) ? 1 : 0);
            chk("arb.if_ready", 32'(if_req_ready), (i % 2 == 1) ? 1 : 0);
            @(posedge clk);
            #1;
            chk("arb.ls_valid", 32'(ls_rsp_valid), (i % 2 == 0) ? 1 : 0);
            chk("arb.if_valid", 32'(if_rsp_valid), (i % 2 == 1) ? 1 : 0);
            chk("arb.ls_data", ls_rsp_data, (i % 2 == 0) ? 32'h11223344 : 32'h0);
            chk("arb.if_data", if_rsp_data, (i % 2 == 1) ? 32'hCAFEF00D : 32'h0);
        end
        idle_in();

        // Error cases: consumed, data 0, no write.
        ls_op("err_sh103", 1'b1, 2'b01, 1'b0, 32'h103, 32'hFFFFFFFF, 32'h0, 1'b1);
        ls_op("err_lw102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1);
        ls_op("err_size3", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        ls_op("err_sw1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hBADBAD00, 32'h0, 1'b1);
        ls_op("err_sb1001", 1'b1, 2'b00, 1'b0, 32'h1101, 32'h000000AA, 32'h0, 1'b1);
        if_op("err_if102", 32'h102, 32'h0, 1'b1);
        if_op("err_if1000", 32'h1000, 32'h0, 1'b1);
        chk("mem_100_kept", mem[32'h40], 32'hDEAD7FEF);
        chk("mem_000_kept", mem[32'h0], 32'hCAFEF00D);

        // Idle: refresh writes only, index 0, no pulses.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle.sram_idx", sram_r_addr, 0);
            chk("idle.ls_valid", 32'(ls_rsp_valid), 0);
            chk("idle.if_valid", 32'(if_rsp_valid), 0);
        end
        if_op("fetch_after_idle", 32'h100, 32'hDEAD7FEF, 1'b0);
        chk("mem_004_kept", mem[32'h1], 32'h11223344);

        // Reset right after a load grant drops its response; LS ends up last winner.
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_size = 2'b10;
        ls_req_unsigned = 1'b0; ls_req_addr = 32'h100;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        #1;
        chk_quiet("mid_rst");
        chk("mid_rst.if_ready", 32'(if_req_ready), 0);
        chk("mid_rst.ls_ready", 32'(ls_req_ready), 0);
        chk("mid_rst.sram_idx", sram_r_addr, 0);
        @(posedge clk);
        #1;
        chk_quiet("mid_rst2");
        idle_in();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst.ls_valid", 32'(ls_rsp_valid), 0);
            chk("post_rst.if_valid", 32'(if_rsp_valid), 0);
            chk("post_rst.sram_idx", sram_r_addr, 0);
        end
        chk("post_rst.mem_100", mem[32'h40], 32'hDEAD7FEF);

        // last_grant back to 0: LS wins the first contention after reset.
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        ls_req_valid = 1'b1; ls_req_addr = 32'h100;
        #1;
        chk("post_rst_arb.ls_ready", 32'(ls_req_ready), 1);
        chk("post_rst_arb.if_ready", 32'(if_req_ready), 0);
        @(posedge clk);
        #1;
        chk("post_rst_arb.ls_data", ls_rsp_data, 32'hDEAD7FEF);
        idle_in();
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dyt_mem_ctrl.md
# dyt_mem_ctrl

Memory access controller that sits directly upstream of the 4 KB single-port-write, single-port-read word SRAM. It arbitrates between the instruction-fetch port and the load/store port and issues at most one access per cycle. It performs byte/halfword read-modify-write merging and load alignment with sign/zero extension. It also produces registered one-cycle responses.

## Interface
- MEM_BYTES, 4096: SRAM capacity in bytes; word index width AW = $clog2(MEM_BYTES/4) = 10.
- WORD_W, 32: data/address word width.
- rst  in  1  asynchronous, active-low reset
- clk  in  1  clock
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  fetch misaligned/out of range
- ls_req_valid  in  1  load/store request
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ls_req_unsigned  in  1  zero-extend load (LBU/LHU)
- ls_req_addr  in  32  byte address
- ls_req_wdata  in  32  store data, right-aligned
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_rsp_valid  out  1  load/store response pulse
- ls_rsp_data  out  32  aligned, extended load data; 0 for stores
- ls_rsp_err  out  1  misaligned/illegal size/out of range
- sram_r_addr  out  32  SRAM read word index, zero-extended
- sram_r_data  in  32  SRAM combinational read data
- sram_w_addr  out  32  SRAM write word index, zero-extended
- sram_w_data  out  32  SRAM write data, written every clock edge

## Operation
- The SRAM writes on every edge and has no enable. The controller always drives sram_w_addr = sram_r_addr.
  - Non-store cycle: sram_w_data = sram_r_data, a benign refresh.
  - Store cycle: sram_w_data = the merged word.
- Idle cycle (no grant): r/w index = 0 and a refresh write.
- Arbitration is combinational and grants one requester per cycle; ready = grant.
  - Only one valid: it wins.
  - Both valid: alternate using register last_grant (0 = IF, 1 = LS). The port not granted last time wins. last_grant updates only on a grant.
  - Reset value last_grant = 0, so LS wins the first contention.
- Word index = addr[AW+1:2].
- Error conditions, checked before any write:
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= MEM_BYTES.
  - IF requests are always word size.
  - An erroring request is still granted and consumed. It performs no write, returns data 0 and err = 1.
- Store merge, byte lane = addr[1:0]:
  - byte: replace lane addr[1:0] with wdata[7:0];
  - half: replace lanes addr[1]*2 +: 2 with wdata[15:0];
  - word: replace the whole word.
  - Unselected lanes keep sram_r_data.
- Load: register the raw word, addr[1:0], size and unsigned at grant. The response stage extracts the lane(s) and sign-extends, or zero-extends if unsigned.
- There is no response backpressure; requesters must sink the rsp pulse.

## Timing
- Request accepted in cycle N (valid & ready high at edge N). The response is valid for exactly cycle N+1.
- Throughput is one access per cycle. Back-to-back grants give back-to-back rsp pulses.
- Store write completes at edge N.
  - A load to the same word granted in N+1 returns the new data.
  - A fetch of that word granted in cycle N (impossible, single grant) is not a case.
- Reset outputs: all rsp_valid/err = 0, rsp_data = 0, last_grant = 0.
- During reset, ready outputs = 0 and sram indices = 0.
- Reset asserted mid-operation: a pending response is dropped and no rsp pulse appears after deassertion.
- The first grant is possible in the first clk edge after rst deasserts.
- Stores with err never modify SRAM contents. This includes addresses ≥ MEM_BYTES, which must not alias via the SRAM modulus.

## Test plan
- Word store 0xDEADBEEF @0x100, then word load @0x100 next cycle -> ls_rsp_valid at N+1 and N+2; second response data 0xDEADBEEF, err 0.
- Byte store 0x7F @0x101 over 0xDEADBEEF, then LB/LBU @0x101 and LH @0x102 -> word 0xDEAD7FEF; LB 0x0000007F; LH 0xFFFFDEAD; LBU @0x103 0x000000DE.
- Both ports valid for 4 cycles, IF @0x0, LS load @0x4 -> grants LS, IF, LS, IF; one rsp pulse per grant on the matching port.
- Misaligned half store @0x103, word load @0x102, size 11, store @0x1000 -> each ls_rsp_err = 1, data 0; memory at 0x100 and 0x000 unchanged.
- Idle for 10 cycles after writes -> contents preserved by refresh writes; fetch @0x100 returns the last stored word.
- rst low at the cycle after a load grant -> no ls_rsp_valid after release; all outputs 0 while low; SRAM reads 0 afterward.
